// File: rtl/video_window_calc.sv
// Centred output-window calculator: turns ARX/ARY (aspect ratio or absolute size) plus the
// HDMI resolution into inclusive HMIN/HMAX/VMIN/VMAX bounds using a shift-add multiplier and restoring divider.
module video_window_calc (
    input  logic        CLK_VIDEO,
    input  logic        RESET_N,
    input  logic [11:0] HDMI_WIDTH,
    input  logic [11:0] HDMI_HEIGHT,
    input  logic [12:0] ARX,
    input  logic [12:0] ARY,
    output logic [11:0] HMIN,
    output logic [11:0] HMAX,
    output logic [11:0] VMIN,
    output logic [11:0] VMAX,
    output logic        VALID
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_MUL, S_DIV, S_CHECK, S_CENTER, S_DONE
    } state_t;

    state_t      state;
    logic [11:0] snap_w, snap_h;
    logic [12:0] snap_ax, snap_ay;
    logic        force_calc;
    logic [23:0] mcand, prod, quo;
    logic [11:0] mplier, rem, den;
    logic [4:0]  cnt;
    logic        second_pass;
    logic [11:0] q, win_w, win_h;
    logic [11:0] sh_hmin, sh_hmax, sh_vmin, sh_vmax;

    logic        change;
    logic [23:0] prod_next, quo_next;
    logic [12:0] trial, diff;
    logic        ge;
    logic [11:0] rem_next, q_sat;
    logic [11:0] hmin_c, hmax_c, vmin_c, vmax_c;

    function automatic logic [11:0] min12(input logic [11:0] a, input logic [11:0] b);
        return (a < b) ? a : b;
    endfunction

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        change    = force_calc || ({HDMI_WIDTH, HDMI_HEIGHT, ARX, ARY} != {snap_w, snap_h, snap_ax, snap_ay});
        prod_next = mplier[0] ? (prod + mcand) : prod;
        trial     = {rem, quo[23]};
        diff      = trial - {1'b0, den};
        ge        = (trial >= {1'b0, den});
        rem_next  = ge ? diff[11:0] : trial[11:0];
        quo_next  = {quo[22:0], ge};
        q_sat     = (|quo_next[23:12]) ? 12'hFFF : quo_next[11:0];
        hmin_c    = 12'd0;
        hmax_c    = 12'd0;
        vmin_c    = 12'd0;
        vmax_c    = 12'd0;
        // The window never exceeds the screen, so the subtractions cannot underflow.
        if (win_w != 12'd0 && win_h != 12'd0) begin
            hmin_c = (snap_w - win_w) >> 1;
            hmax_c = hmin_c + win_w - 12'd1;
            vmin_c = (snap_h - win_h) >> 1;
            vmax_c = vmin_c + win_h - 12'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            snap_w      <= '0;
            snap_h      <= '0;
            snap_ax     <= '0;
            snap_ay     <= '0;
            force_calc  <= 1'b1;
            mcand       <= '0;
            prod        <= '0;
            quo         <= '0;
            mplier      <= '0;
            rem         <= '0;
            den         <= '0;
            cnt         <= '0;
            second_pass <= 1'b0;
            q           <= '0;
            win_w       <= '0;
            win_h       <= '0;
            sh_hmin     <= '0;
            sh_hmax     <= '0;
            sh_vmin     <= '0;
            sh_vmax     <= '0;
            HMIN        <= '0;
            HMAX        <= '0;
            VMIN        <= '0;
            VMAX        <= '0;
            VALID       <= 1'b0;
        end else if (change) begin
            // Any input change (or the first edge after reset) restarts; outputs hold.
            snap_w     <= HDMI_WIDTH;
            snap_h     <= HDMI_HEIGHT;
            snap_ax    <= ARX;
            snap_ay    <= ARY;
            force_calc <= 1'b0;
            VALID      <= 1'b0;
            state      <= S_SEL;
        end else begin
            case (state)
                S_IDLE: ;
                S_SEL: begin
                    if (snap_ax[12]) begin
                        win_w <= min12(snap_ax[11:0], snap_w);
                        win_h <= min12(snap_ay[11:0], snap_h);
                        state <= S_CENTER;
                    end else if (snap_ax[11:0] == 12'd0 || snap_ay[11:0] == 12'd0) begin
                        win_w <= snap_w;
                        win_h <= snap_h;
                        state <= S_CENTER;
                    end else begin
                        mcand       <= {12'd0, snap_h};
                        mplier      <= snap_ax[11:0];
                        den         <= snap_ay[11:0];
                        prod        <= '0;
                        cnt         <= '0;
                        second_pass <= 1'b0;
                        state       <= S_MUL;
                    end
                end
                S_MUL: begin
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd11) begin
                        rem   <= '0;
                        quo   <= prod_next;
                        cnt   <= '0;
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd23) begin
                        cnt <= '0;
                        if (second_pass) begin
                            win_h <= min12(q_sat, snap_h);
                            state <= S_CENTER;
                        end else begin
                            q     <= q_sat;
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (q <= snap_w) begin
                        win_w <= q;
                        win_h <= snap_h;
                        state <= S_CENTER;
                    end else begin
                        // Too wide: pin width to the screen and derive height from W*AY/AX.
                        win_w       <= snap_w;
                        mcand       <= {12'd0, snap_w};
                        mplier      <= snap_ay[11:0];
                        den         <= snap_ax[11:0];
                        prod        <= '0;
                        cnt         <= '0;
                        second_pass <= 1'b1;
                        state       <= S_MUL;
                    end
                end
                S_CENTER: begin
                    sh_hmin <= hmin_c;
                    sh_hmax <= hmax_c;
                    sh_vmin <= vmin_c;
                    sh_vmax <= vmax_c;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    HMIN  <= sh_hmin;
                    HMAX  <= sh_hmax;
                    VMIN  <= sh_vmin;
                    VMAX  <= sh_vmax;
                    VALID <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_window_calc.sv
// Directed bench for video_window_calc: a vector table of resolutions/aspect words with
// hand-computed latencies and bounds, plus abort and mid-computation reset sequences.
module tb_video_window_calc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] hdmi_width, hdmi_height;
    logic [12:0] arx, ary;
    logic [11:0] hmin, hmax, vmin, vmax;
    logic        valid;

    int checks = 0;
    int errors = 0;
    logic [11:0] p_hmin, p_hmax, p_vmin, p_vmax;

    typedef struct {
        string       name;
        logic [11:0] w, h;
        logic [12:0] ax, ay;
        int          edges;
        logic [11:0] e_hmin, e_hmax, e_vmin, e_vmax;
    } vec_t;

    vec_t vecs[10];

    video_window_calc dut (
        .CLK_VIDEO  (clk),
        .RESET_N    (rst_n),
        .HDMI_WIDTH (hdmi_width),
        .HDMI_HEIGHT(hdmi_height),
        .ARX        (arx),
        .ARY        (ary),
        .HMIN       (hmin),
        .HMAX       (hmax),
        .VMIN       (vmin),
        .VMAX       (vmax),
        .VALID      (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [11:0] w, input logic [11:0] h,
                         input logic [12:0] ax, input logic [12:0] ay);
        hdmi_width  = w;
        hdmi_height = h;
        arx         = ax;
        ary         = ay;
    endtask

    // Called at a negedge just after new inputs are driven; the next posedge is edge 0.
    task automatic run_vec(input string name, input int exp_edges,
                           input logic [11:0] e_hmin, input logic [11:0] e_hmax,
                           input logic [11:0] e_vmin, input logic [11:0] e_vmax);
        int n;
        int held;
        n    = -1;
        held = 1;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (valid) break;
            if ({hmin, hmax, vmin, vmax} != {p_hmin, p_hmax, p_vmin, p_vmax}) held = 0;
        end
        check({name, " valid_edge"}, n, exp_edges);
        check({name, " hold"}, held, 1);
        check({name, " hmin"}, int'(hmin), int'(e_hmin));
        check({name, " hmax"}, int'(hmax), int'(e_hmax));
        check({name, " vmin"}, int'(vmin), int'(e_vmin));
        check({name, " vmax"}, int'(vmax), int'(e_vmax));
        p_hmin = e_hmin;
        p_hmax = e_hmax;
        p_vmin = e_vmin;
        p_vmax = e_vmax;
        repeat (5) @(posedge clk);
        #1;
        check({name, " valid_steady"}, int'(valid), 1);
        @(negedge clk);
    endtask

    initial begin
        int held;

        vecs[0] = '{"ar16_9_pathB", 12'd1280, 12'd1024, 13'd16,    13'd9,    76, 12'd0,    12'd1279, 12'd152, 12'd871};
        vecs[1] = '{"abs_1280x960", 12'd1920, 12'd1080, 13'h1500,  13'h13C0, 3,  12'd320,  12'd1599, 12'd60,  12'd1019};
        vecs[2] = '{"abs_clamp",    12'd1920, 12'd1080, 13'h17D0,  13'h14B0, 3,  12'd0,    12'd1919, 12'd0,   12'd1079};
        vecs[3] = '{"full_arx0",    12'd1920, 12'd1080, 13'd0,     13'd3,    3,  12'd0,    12'd1919, 12'd0,   12'd1079};
        vecs[4] = '{"full_w0",      12'd0,    12'd1080, 13'd0,     13'd3,    3,  12'd0,    12'd0,    12'd0,   12'd0};
        vecs[5] = '{"aspect_w0",    12'd0,    12'd1080, 13'd4,     13'd3,    76, 12'd0,    12'd0,    12'd0,   12'd0};
        vecs[6] = '{"full_ary0",    12'd1920, 12'd1080, 13'd4,     13'd0,    3,  12'd0,    12'd1919, 12'd0,   12'd1079};
        vecs[7] = '{"q_eq_w",       12'd1920, 12'd1080, 13'd16,    13'd9,    40, 12'd0,    12'd1919, 12'd0,   12'd1079};
        vecs[8] = '{"abs_odd",      12'd1001, 12'd1000, 13'h11F4,  13'h112C, 3,  12'd250,  12'd749,  12'd350, 12'd649};
        vecs[9] = '{"q_saturate",   12'd4095, 12'd4095, 13'd4095,  13'd1,    40, 12'd0,    12'd4094, 12'd0,   12'd4094};

        rst_n = 1'b0;
        drive(12'd1920, 12'd1080, 13'd4, 13'd3);
        p_hmin = '0; p_hmax = '0; p_vmin = '0; p_vmax = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset valid", int'(valid), 0);
        check("reset bounds", int'({hmin, hmax, vmin, vmax} == 48'd0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_reset_4_3", 40, 12'd240, 12'd1679, 12'd0, 12'd1079);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].w, vecs[i].h, vecs[i].ax, vecs[i].ay);
            run_vec(vecs[i].name, vecs[i].edges, vecs[i].e_hmin, vecs[i].e_hmax,
                    vecs[i].e_vmin, vecs[i].e_vmax);
        end

        // Abort: start 16:9, then move ARY to 10 so that the change lands on edge 20.
        drive(12'd1920, 12'd1080, 13'd4, 13'd3);
        run_vec("settle_4_3", 40, 12'd240, 12'd1679, 12'd0, 12'd1079);
        drive(12'd1920, 12'd1080, 13'd16, 13'd9);
        held = 1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (valid || {hmin, hmax, vmin, vmax} != {p_hmin, p_hmax, p_vmin, p_vmax}) held = 0;
        end
        check("abort first_run_hold", held, 1);
        @(negedge clk);
        ary = 13'd10;
        run_vec("abort_16_10", 40, 12'd96, 12'd1823, 12'd0, 12'd1079);

        // Reset asserted at edge 25 of a computation.
        drive(12'd1920, 12'd1080, 13'd4, 13'd3);
        for (int e = 0; e <= 25; e++) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst valid", int'(valid), 0);
        check("midrst hmin", int'(hmin), 0);
        check("midrst hmax", int'(hmax), 0);
        check("midrst vmax", int'(vmax), 0);
        p_hmin = '0; p_hmax = '0; p_vmin = '0; p_vmax = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_vec("midrst_rerun", 40, 12'd240, 12'd1679, 12'd0, 12'd1079);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
